sm_mcu_mem_stream_reader: RTL
=============================

// Module: sm_mcu_mem_stream_reader
// PURPOSE
//  Avalon-MM read master (initiator) for the 32-bit on-chip memory slave (fixed read latency, no readdatavalid).
//  Fetches a block of words from a word base address and presents them on a valid/ready stream to the TFT pixel path.
//  Buffers the data in an internal show-ahead FIFO. Issues a read only when FIFO space is guaranteed for it.
// PARAMETERS
//  ADDR_W       10  word-address width (wraps mod 2**ADDR_W)
//  DATA_W       32  data width
//  LEN_W        11  transfer-length width, in words
//  FIFO_DEPTH   8   output FIFO depth; power of 2, >= READ_LATENCY+1
//  READ_LATENCY 1   cycles from an accepted read to m_readdata being valid
// PORTS
//  clk          in   1       single clock; every flop is clocked on the rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       pulse: load base/len and begin; ignored unless state==IDLE
//  base_addr    in   ADDR_W  first word address
//  len          in   LEN_W   number of words (0 = empty transfer)
//  abort        in   1       pulse: cancel the current transfer
//  busy         out  1       high in any state other than IDLE
//  done         out  1       1-cycle pulse when the final word is accepted on the stream
//  m_address    out  ADDR_W  Avalon word address
//  m_chipselect out  1       asserted together with m_read
//  m_read       out  1       read request
//  m_byteenable out  DATA_W/8 always all ones
//  m_readdata   in   DATA_W  slave read data
//  m_waitrequest in  1       slave stall; tie 0 for the on-chip memory
//  st_data      out  DATA_W  stream data (FIFO head)
//  st_valid     out  1       FIFO not empty
//  st_ready     in   1       downstream accept
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, m_read, m_chipselect, st_valid = 0; m_address = 0; FIFO empty; in-flight = 0.
//  Request accept: a read is accepted in any cycle with m_read & ~m_waitrequest.
//    - m_address/m_read stay stable while m_waitrequest=1.
//  Read-data capture: an accepted read pushes m_readdata into the FIFO exactly READ_LATENCY cycles later.
//    - Tracked with a READ_LATENCY-deep valid shift register; in_flight = popcount of that register.
//  Issue rule: m_read=1 only when remaining>0 and fifo_count + in_flight + (accepted this cycle) < FIFO_DEPTH.
//    - The FIFO can therefore never overflow; back-to-back reads sustain 1 word/clk when st_ready=1.
//  Stream handshake: st_valid/st_data are registered FIFO-head outputs. A word pops when st_valid & st_ready.
//    - st_data is held stable while st_valid & ~st_ready.
//  FIFO push and pop in the same cycle: count is unchanged; permitted when full and when empty+push (show-ahead next cycle).
//  State machine:
//    - IDLE: start & len!=0 -> READ, with addr=base_addr and remaining=len.
//    - IDLE: start & len==0 -> stay in IDLE, with done pulsed on the next cycle.
//    - READ: each accepted read does addr+1 (wraps 2**ADDR_W-1 -> 0) and remaining-1. Remaining reaching 0 -> DRAIN.
//    - DRAIN: in_flight==0 & FIFO empty after the last pop -> IDLE, with done=1 for that one cycle.
//    - abort in READ/DRAIN -> FLUSH: m_read drops the same cycle, FIFO is cleared, st_valid=0 next cycle.
//      Returning read data is discarded. in_flight==0 -> IDLE. done is not pulsed.
//  Simultaneous events:
//    - abort has priority over an accept or pop in the same cycle.
//    - start in the cycle done is asserted (state already IDLE) is accepted.
//    - start while busy is ignored.
//  Reset mid-transfer: immediate return to reset values; any slave reads in flight are ignored.
// CONFIGURATION
//  SM_MCU_STREAM_LOOP_EN defined:
//    - Adds input port loop (1 bit).
//    - When the final word of a transfer is accepted with loop=1: done pulses, state goes straight to READ,
//      addr=base, remaining=len, without visiting IDLE. This gives continuous frame refresh.
//    - abort exits the loop.
//  Not defined: the port is absent; every transfer ends in IDLE.
// TESTING
//  Single word: start, base=0x010, len=1, st_ready=1 -> one read at 0x010; st_data=mem[0x010];
//    done one cycle after the pop; busy=0.
//  Throughput: len=16, st_ready=1, waitrequest=0 -> 16 consecutive read cycles, addresses 0x000..0x00F,
//    16 stream words in order, no gaps after the first.
//  Backpressure: len=20, st_ready=0 for 30 cycles -> exactly FIFO_DEPTH(8) reads issued, m_read then 0, no data loss;
//    releasing st_ready delivers all 20 words.
//  Wrap + stall: base=0x3FE, len=4, waitrequest high on alternate cycles -> addresses 0x3FE,0x3FF,0x000,0x001,
//    each held during its stall; data correct.
//  Abort: abort after 5 of 12 words accepted -> m_read=0 that cycle, st_valid=0 the next cycle, no done,
//    IDLE once in_flight=0; a new start then works.
//  Zero length and reset: len=0 -> done one cycle later with no m_read.
//    reset_n low mid-transfer -> all outputs at reset values asynchronously.
//  Loop (with SM_MCU_STREAM_LOOP_EN): loop=1, base=0x100, len=3 -> repeating addresses 0x100..0x102,
//    done every 3rd accepted word; abort stops it.

Source files
------------

// File: rtl/sm_mcu_mem_stream_reader.sv
// Avalon-MM read master that streams a block of words through a show-ahead FIFO; optional loop mode via SM_MCU_STREAM_LOOP_EN.
// Latency: first word on st_data 3 cycles after start (READ_LATENCY=1), then 1 word/clk sustained.
// Backpressure: reads are issued only while FIFO + in-flight words leave room, so st_ready low stalls m_read without loss.
module sm_mcu_mem_stream_reader #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 11,
    parameter int FIFO_DEPTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len,
    input  logic                abort,
`ifdef SM_MCU_STREAM_LOOP_EN
    input  logic                loop,
`endif
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_read,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    remaining;
`ifdef SM_MCU_STREAM_LOOP_EN
    logic [ADDR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
`endif
    logic                m_read_q;
    logic [READ_LATENCY-1:0] pipe;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0]    count, count_next;
    logic [DATA_W-1:0]   head_next;
    logic [DATA_W-1:0]   st_data_q;
    logic                st_valid_q;

    logic                active, flush, accept, push, pop, room_next;
    logic [7:0]          in_flight, inflight_next;

    // Abort must kill the request combinationally in the cycle it arrives.
    assign m_read       = m_read_q & ~abort;
    assign m_chipselect = m_read;
    assign m_address    = addr;
    assign m_byteenable = '1;
    assign st_data      = st_data_q;
    assign st_valid     = st_valid_q;

    assign accept = m_read & ~m_waitrequest;
    assign active = (state == READ) || (state == DRAIN);
    assign flush  = active & abort;
    assign push   = pipe[READ_LATENCY-1] & active & ~abort;
    assign pop    = st_valid_q & st_ready;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + 8'(pipe[i]);
        end
    end

    always_comb begin
        count_next    = count;
        rd_ptr_next   = rd_ptr;
        head_next     = st_data_q;
        inflight_next = in_flight - 8'(pipe[READ_LATENCY-1]) + 8'(accept);
        if (flush) begin
            count_next  = '0;
            rd_ptr_next = '0;
        end else begin
            count_next  = count + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_next = rd_ptr + PTR_W'(pop);
        end
        // A word landing in an otherwise empty FIFO bypasses the array to become the head.
        if (!flush && push && count_next == CNT_W'(1)) begin
            head_next = m_readdata;
        end else begin
            head_next = mem[rd_ptr_next];
        end
        room_next = (16'(count_next) + 16'(inflight_next)) < 16'(FIFO_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= m_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe       <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            st_valid_q <= 1'b0;
            st_data_q  <= '0;
        end else begin
            pipe[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            count      <= count_next;
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= flush ? '0 : wr_ptr + PTR_W'(push);
            st_valid_q <= (count_next != '0);
            st_data_q  <= head_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            m_read_q  <= 1'b0;
`ifdef SM_MCU_STREAM_LOOP_EN
            base_q    <= '0;
            len_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state     <= READ;
                            busy      <= 1'b1;
                            addr      <= base_addr;
                            remaining <= len;
                            m_read_q  <= 1'b1;
`ifdef SM_MCU_STREAM_LOOP_EN
                            base_q    <= base_addr;
                            len_q     <= len;
`endif
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state    <= FLUSH;
                        m_read_q <= 1'b0;
                    end else begin
                        if (accept) begin
                            addr      <= addr + ADDR_W'(1);
                            remaining <= remaining - LEN_W'(1);
                        end
                        if (accept && remaining == LEN_W'(1)) begin
                            state    <= DRAIN;
                            m_read_q <= 1'b0;
                        end else begin
                            // A stalled request is held; otherwise reissue only with guaranteed FIFO room.
                            m_read_q <= (m_read_q & m_waitrequest) | room_next;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= FLUSH;
                    end else if (count_next == '0 && inflight_next == 8'd0) begin
                        done <= 1'b1;
`ifdef SM_MCU_STREAM_LOOP_EN
                        if (loop) begin
                            state     <= READ;
                            addr      <= base_q;
                            remaining <= len_q;
                            m_read_q  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
                FLUSH: begin
                    if (in_flight == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
